// File: rtl/fc_layer_engine.sv
// fc_layer_engine: fully-connected layer evaluator. Reads inputs and weights
// from a single-port RAM, accumulates one neuron at a time, and writes one
// shifted, optionally rectified, saturated result per output neuron.
module fc_layer_engine #(
  parameter int IN_CELL  = 14,
  parameter int OUT_CELL = 10,
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int FRAC     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          relu_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_we,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  localparam int PROD_W = 2 * DW;
  localparam int ACC_W  = 2 * DW + 8;

  localparam logic [AW-1:0] I_LAST   = AW'(IN_CELL - 1);
  localparam logic [AW-1:0] O_LAST   = AW'(OUT_CELL - 1);
  localparam logic [AW-1:0] W_STRIDE = AW'(IN_CELL);

  // Clamp bounds of the DW-bit result, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RD_X, RD_W, MAC, WB, DONE} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             i_q, o_q;
  logic [AW-1:0]             w_base_q;   // address of w[o][0]
  logic signed [DW-1:0]      x_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      relu_q;

  logic signed [PROD_W-1:0]  x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]   prod_ext, acc_shr;
  logic [DW-1:0]             result;

  // Full-precision signed product of the latched input and the weight on the bus.
  assign x_ext    = {{DW{x_q[DW-1]}}, x_q};
  assign w_ext    = {{DW{mem_rdata[DW-1]}}, mem_rdata};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_shr  = acc_q >>> FRAC;

  // Rescale, optionally rectify, then saturate the accumulated dot product.
  always_comb begin
    if (relu_q && acc_shr[ACC_W-1])  result = '0;
    else if (acc_shr > SAT_MAX)      result = SAT_MAX[DW-1:0];
    else if (acc_shr < SAT_MIN)      result = SAT_MIN[DW-1:0];
    else                             result = acc_shr[DW-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of its sources, independent of block ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Counters, operand latch and accumulator, advanced by the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q      <= '0;
      o_q      <= '0;
      w_base_q <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      relu_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            i_q      <= '0;
            o_q      <= '0;
            w_base_q <= W_STRIDE;
            acc_q    <= '0;
            relu_q   <= relu_en;
          end
        end
        RD_W: x_q <= mem_rdata;
        MAC: begin
          acc_q <= acc_q + prod_ext;
          if (i_q != I_LAST) i_q <= i_q + AW'(1);
        end
        WB: begin
          acc_q    <= '0;
          i_q      <= '0;
          w_base_q <= w_base_q + W_STRIDE;
          if (o_q != O_LAST) o_q <= o_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and state-driven outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    mem_addr = '0;
    out_we   = 1'b0;
    out_addr = '0;
    out_data = '0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RD_X;
      RD_X: begin
        mem_addr = i_q;
        state_d  = RD_W;
      end
      RD_W: begin
        mem_addr = w_base_q + i_q;
        state_d  = MAC;
      end
      MAC:  state_d = (i_q == I_LAST) ? WB : RD_X;
      WB: begin
        // A write-back caught by reset is suppressed rather than half-issued.
        if (!reset) begin
          out_we   = 1'b1;
          out_addr = o_q;
          out_data = result;
        end
        state_d = (o_q == O_LAST) ? DONE : RD_X;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  IN_CELL, 14, number of input cells per output neuron.
  OUT_CELL, 10, number of output neurons.
  DW, 16, data width (signed two's complement, fixed point).
  AW, 16, memory address width.
  FRAC, 8, fractional bits of the data and weight format.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  rising-edge clock.
  reset  in  1  synchronous active-high reset.
  start  in  1  begin one layer pass; sampled in IDLE only.
  relu_en  in  1  apply ReLU to each result; sampled at start accept, held for the pass.
  mem_addr  out  AW  read address to single-port RAM.
  mem_rdata  in  DW  RAM read data; valid exactly 1 cycle after mem_addr.
  out_we  out  1  result write strobe, one cycle per neuron.
  out_addr  out  AW  result index 0..OUT_CELL-1.
  out_data  out  DW  saturated result.
  busy  out  1  high in every non-IDLE state.
  done  out  1  one-cycle pulse at end of pass.

Function
REQ-004 Memory map SHALL be: input x[i] at address i; weight w[o][i] at address IN_CELL + o*IN_CELL + i.
REQ-005 FSM states SHALL be IDLE, RD_X, RD_W, MAC, WB, DONE.
REQ-006 IDLE: start=1 -> RD_X with i=0, o=0, accumulator=0, relu_en latched; otherwise stay.
REQ-007 RD_X SHALL drive mem_addr=i and go to RD_W.
REQ-008 RD_W SHALL latch x from mem_rdata, drive mem_addr=IN_CELL+o*IN_CELL+i, and go to MAC.
REQ-009 MAC SHALL latch w from mem_rdata and add x*w (full 2*DW signed product) to the accumulator; if i<IN_CELL-1, increment i and go to RD_X; else go to WB.
REQ-010 The accumulator SHALL be 2*DW+8 bits signed and SHALL never wrap for IN_CELL<=256.
REQ-011 WB SHALL assert out_we for one cycle with out_addr=o and out_data=sat(relu(acc >>> FRAC)):
  - arithmetic right shift;
  - relu maps negative to 0 only when latched relu_en=1;
  - sat clamps to [-2^(DW-1), 2^(DW-1)-1].
REQ-012 After WB: clear accumulator and i; if o<OUT_CELL-1, increment o and go to RD_X; else go to DONE.
REQ-013 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-014 Latency SHALL be exactly OUT_CELL*(3*IN_CELL+1)+1 cycles from the start-accept edge to done high (431 at defaults).
REQ-015 start while busy=1 SHALL be ignored; start held high in DONE SHALL NOT be accepted before IDLE is reached.
REQ-016 A new pass MAY be accepted on the cycle after done (back-to-back).
REQ-017 mem_addr SHALL be 0 in IDLE, WB and DONE.
REQ-018 out_addr and out_data SHALL be 0 whenever out_we=0.
REQ-019 mem_rdata SHALL be ignored outside RD_W and MAC.

Reset
REQ-020 reset=1 at a rising edge SHALL force IDLE with busy=0, done=0, out_we=0, out_addr=0, out_data=0, mem_addr=0, i=o=0 and accumulator=0, from any state including mid-pass.
REQ-021 No out_we pulse SHALL occur in the cycle reset is asserted or the cycle after it.
REQ-022 The pass aborted by reset SHALL NOT be resumed; a fresh start is required.

Verification
REQ-023 IN_CELL=2, OUT_CELL=1, x=[256,512], w=[128,-256], relu_en=0 -> one out_we with out_addr=0, out_data=-384; done 8 cycles after start.
REQ-024 Same data with relu_en=1 -> out_data=0.
REQ-025 IN_CELL=2, x=[32767,32767], w=[32767,32767] -> out_data=32767 (positive saturation); negated w -> -32768.
REQ-026 Defaults with random RAM -> 10 out_we pulses with out_addr 0..9 matching a reference model; done at cycle 431; start pulses during busy have no effect.
REQ-027 reset asserted at cycle 100 of a default pass -> next edge busy=0 and all outputs 0; a restart yields results identical to an uninterrupted pass.
